fifo_param: RTL and testbench

Parametrised synchronous FIFO, the successor to the fixed 8×8 FIFO. Data width, depth and watermark thresholds are parameters. Adds almost-full/almost-empty watermarks, a read-valid strobe, sticky overflow/underflow error flags and a synchronous flush. It sits between producer and consumer blocks in the same clock domain, wherever buffering with back-pressure visibility is needed.

---
 rtl/fifo_param.sv | 120 ++++++++++++
 tb/tb_fifo_param.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with watermarks, registered read data, a read-valid
// strobe, sticky overflow/underflow flags and a synchronous flush.
module fifo_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 3,
    parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] fifo_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] fifo_out,
    output logic                  fifo_out_valid,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  fifo_almost_empty,
    output logic                  fifo_almost_full,
    output logic [ADDR_WIDTH:0]   fifo_counter,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   FULL_CNT   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AFULL_CNT  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0]   AEMPTY_CNT = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_WIDTH:0]   count_reg, count_next;
    logic                  overflow_reg, overflow_next;
    logic                  underflow_reg, underflow_next;
    logic [DATA_WIDTH-1:0] out_reg;
    logic                  valid_reg;

    logic empty_w;
    logic full_w;
    logic pop_ok;
    logic push_ok;

    assign empty_w = (count_reg == '0);
    assign full_w  = (count_reg == FULL_CNT);

    // flush masks both requests so a coincident push/pop neither moves data nor flags an error
    assign pop_ok  = pop  & ~flush & ~empty_w;
    assign push_ok = push & ~flush & (~full_w | pop_ok);

    always_comb begin
        rd_ptr_next    = rd_ptr_reg;
        wr_ptr_next    = wr_ptr_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;
        if (flush) begin
            rd_ptr_next    = '0;
            wr_ptr_next    = '0;
            count_next     = '0;
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end else begin
            if (pop_ok)
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            if (push_ok)
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            if (push_ok && !pop_ok)
                count_next = count_reg + CNT_ONE;
            else if (pop_ok && !push_ok)
                count_next = count_reg - CNT_ONE;
            if (push && !push_ok)
                overflow_next = 1'b1;
            if (pop && !pop_ok)
                underflow_next = 1'b1;
        end
    end

    // Storage carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= fifo_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            out_reg       <= '0;
            valid_reg     <= 1'b0;
        end else begin
            rd_ptr_reg    <= rd_ptr_next;
            wr_ptr_reg    <= wr_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
            valid_reg     <= pop_ok;
            if (pop_ok)
                out_reg <= mem[rd_ptr_reg];
        end
    end

    assign fifo_out          = out_reg;
    assign fifo_out_valid    = valid_reg;
    assign fifo_counter      = count_reg;
    assign fifo_empty        = empty_w;
    assign fifo_full         = full_w;
    assign fifo_almost_empty = (count_reg <= AEMPTY_CNT);
    assign fifo_almost_full  = (count_reg >= AFULL_CNT);
    assign overflow          = overflow_reg;
    assign underflow         = underflow_reg;

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param (default parameters): a behavioural occupancy model
// feeds an expected-output scoreboard that is drained whenever the DUT strobes valid.
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       push = 1'b0;
    logic [7:0] fifo_in = '0;
    logic       pop = 1'b0;
    logic [7:0] fifo_out;
    logic       fifo_out_valid;
    logic       fifo_empty;
    logic       fifo_full;
    logic       fifo_almost_empty;
    logic       fifo_almost_full;
    logic [3:0] fifo_counter;
    logic       overflow;
    logic       underflow;

    fifo_param dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .push              (push),
        .fifo_in           (fifo_in),
        .pop               (pop),
        .fifo_out          (fifo_out),
        .fifo_out_valid    (fifo_out_valid),
        .fifo_empty        (fifo_empty),
        .fifo_full         (fifo_full),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_almost_full  (fifo_almost_full),
        .fifo_counter      (fifo_counter),
        .overflow          (overflow),
        .underflow         (underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] model_q [$];
    logic [7:0] sb_q [$];
    logic [7:0] model_out   = '0;
    logic       model_valid = 1'b0;
    logic       model_ovf   = 1'b0;
    logic       model_udf   = 1'b0;
    int         max_count   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        int cnt;
        cnt = model_q.size();
        check({tag, " count"},     32'(fifo_counter),      32'(cnt));
        check({tag, " empty"},     32'(fifo_empty),        32'(cnt == 0));
        check({tag, " full"},      32'(fifo_full),         32'(cnt == 8));
        check({tag, " aempty"},    32'(fifo_almost_empty), 32'(cnt <= 1));
        check({tag, " afull"},     32'(fifo_almost_full),  32'(cnt >= 6));
        check({tag, " overflow"},  32'(overflow),          32'(model_ovf));
        check({tag, " underflow"}, 32'(underflow),         32'(model_udf));
        check({tag, " valid"},     32'(fifo_out_valid),    32'(model_valid));
        check({tag, " fifo_out"},  32'(fifo_out),          32'(model_out));
    endtask

    // One clock cycle of stimulus; model and scoreboard are updated from the requests alone.
    task automatic step(input string tag, input bit f, input bit ps, input logic [7:0] d, input bit pp);
        bit pop_ok, push_ok;
        flush = f; push = ps; fifo_in = d; pop = pp;
        if (f) begin
            model_q.delete();
            model_ovf = 1'b0;
            model_udf = 1'b0;
            model_valid = 1'b0;
        end else begin
            pop_ok  = pp && (model_q.size() > 0);
            push_ok = ps && ((model_q.size() < 8) || pop_ok);
            if (pop_ok) begin
                model_out = model_q.pop_front();
                sb_q.push_back(model_out);
            end
            if (push_ok) model_q.push_back(d);
            if (ps && !push_ok) model_ovf = 1'b1;
            if (pp && !pop_ok) model_udf = 1'b1;
            model_valid = pop_ok;
        end
        if (model_q.size() > max_count) max_count = model_q.size();
        @(posedge clk);
        #1;
        flush = 1'b0; push = 1'b0; pop = 1'b0;
        if (fifo_out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check({tag, " unexpected valid"}, 32'(fifo_out_valid), 32'(0));
            end else begin
                logic [7:0] e;
                e = sb_q.pop_front();
                check({tag, " sb data"}, 32'(fifo_out), 32'(e));
            end
        end
        sb_q.delete();
        check_status(tag);
        $display("step %-10s f=%0b push=%0b din=%02h pop=%0b -> out=%02h v=%0b cnt=%0d ovf=%0b udf=%0b",
                 tag, f, ps, d, pp, fifo_out, fifo_out_valid, fifo_counter, overflow, underflow);
    endtask

    initial begin
        // Asynchronous reset: outputs must settle without a clock edge.
        #2 rst = 1'b0;
        #1 check_status("reset");
        #9 rst = 1'b1;

        for (int i = 0; i < 8; i++) step("fill", 0, 1, 8'(8'h10 + i), 0);
        step("push_full", 0, 1, 8'hEE, 0);
        step("full_pp", 0, 1, 8'hAA, 1);
        for (int i = 0; i < 8; i++) step("drain", 0, 0, 8'h00, 1);
        step("pop_empty", 0, 0, 8'h00, 1);

        for (int i = 0; i < 20; i++) begin
            bit ps, pp;
            ps = ((i % 6) < 4);
            pp = ((i % 6) >= 2);
            step("wrap", 0, ps, 8'(8'h30 + i), pp);
        end
        while (model_q.size() > 0) step("wrap_drn", 0, 0, 8'h00, 1);
        check("wrap max count", 32'(max_count <= 8), 32'(1));

        step("flush", 1, 0, 8'h00, 1);
        step("empty_pp", 0, 1, 8'h55, 1);
        step("pop_55", 0, 0, 8'h00, 1);

        for (int i = 0; i < 5; i++) step("fill5", 0, 1, 8'(8'h60 + i), 0);
        step("push_full", 0, 0, 8'h00, 0);
        step("flush_ps", 1, 1, 8'h77, 0);
        step("post_fl", 0, 1, 8'h88, 0);
        step("pop_88", 0, 0, 8'h00, 1);

        for (int i = 0; i < 3; i++) step("burst", 0, 1, 8'(8'h90 + i), 0);
        step("burst_pop", 0, 1, 8'h93, 1);
        #3 rst = 1'b0;
        model_q.delete();
        model_out = '0; model_valid = 1'b0; model_ovf = 1'b0; model_udf = 1'b0;
        #1 check_status("mid_reset");
        #7 rst = 1'b1;
        step("after_rst", 0, 1, 8'hC3, 0);
        step("pop_c3", 0, 0, 8'h00, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
